// File: rtl/regfile_wq_pkg.sv
// Shared constants and the queue entry type for the register file write queue.
package regfile_wq_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 16;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/wq_match_lookup.sv
// Youngest-match search over the write queue entries, walking backwards from the tail.
module wq_match_lookup
    import regfile_wq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wq_entry_t [DEPTH-1:0]         entries,
    input  logic [$clog2(DEPTH)-1:0]      tail,
    input  logic [ADDR_W-1:0]             lkAddr,
    output logic                          hit,
    output logic [DATA_W-1:0]             data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the last match written is the newest pending value.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (entries[idx].valid && (entries[idx].addr == lkAddr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Buffered writer for the register file write port, with two forwarding lookup ports.
// Optional build macro REGFILE_WQ_COALESCE_EN merges a push into the youngest entry on address match.
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = regfile_wq_pkg::DATA_W,
    parameter int ADDR_W = regfile_wq_pkg::ADDR_W,
    parameter int NREGS  = regfile_wq_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_stall,
    output logic                     rf_regWrite,
    output logic [ADDR_W-1:0]        rf_wrAddr,
    output logic [DATA_W-1:0]        rf_wrData,
    input  logic [ADDR_W-1:0]        lk_addr1,
    input  logic [ADDR_W-1:0]        lk_addr2,
    output logic                     lk_hit1,
    output logic                     lk_hit2,
    output logic [DATA_W-1:0]        lk_data1,
    output logic [DATA_W-1:0]        lk_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    import regfile_wq_pkg::wq_entry_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wq_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    logic full;
    logic empty;
    logic addrLegal;
    logic accept;
    logic alloc;
    logic pop;
    logic coalesce;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign addrLegal = (32'(in_addr) < NREGS);
    assign pop       = !empty && !rf_stall;

`ifdef REGFILE_WQ_COALESCE_EN
    logic [PTR_W-1:0] youngIdx;

    // Merging is only safe when the youngest entry is not leaving the queue this cycle.
    assign youngIdx = tail - 1'b1;
    assign coalesce = in_valid && addrLegal && !empty
                   && entries[youngIdx].valid
                   && (entries[youngIdx].addr == in_addr)
                   && !(pop && (count == CNT_W'(1)));
    assign in_ready = !full || coalesce;
`else
    assign coalesce = 1'b0;
    assign in_ready = !full;
`endif

    assign accept = in_valid && in_ready;
    assign alloc  = accept && addrLegal && !coalesce;

    assign rf_regWrite = pop;
    assign rf_wrAddr   = empty ? '0 : entries[head].addr;
    assign rf_wrData   = empty ? '0 : entries[head].data;

    // Pointer, occupancy and drop-pulse bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= accept && !addrLegal;
            if (alloc) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; alloc and pop can never target the same slot since that needs full and empty at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries <= '0;
        end else begin
            if (alloc) begin
                entries[tail] <= '{valid: 1'b1, addr: in_addr, data: in_data};
            end
`ifdef REGFILE_WQ_COALESCE_EN
            if (accept && coalesce) begin
                entries[youngIdx].data <= in_data;
            end
`endif
            if (pop) begin
                entries[head].valid <= 1'b0;
            end
        end
    end

    wq_match_lookup #(.DEPTH(DEPTH)) lookup1 (
        .entries (entries),
        .tail    (tail),
        .lkAddr  (lk_addr1),
        .hit     (lk_hit1),
        .data    (lk_data1)
    );

    wq_match_lookup #(.DEPTH(DEPTH)) lookup2 (
        .entries (entries),
        .tail    (tail),
        .lkAddr  (lk_addr2),
        .hit     (lk_hit2),
        .data    (lk_data2)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue; honours REGFILE_WQ_COALESCE_EN for the merge step.
module tb_regfile_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        rf_stall;
    logic        rf_regWrite;
    logic [4:0]  rf_wrAddr;
    logic [31:0] rf_wrData;
    logic [4:0]  lk_addr1;
    logic [4:0]  lk_addr2;
    logic        lk_hit1;
    logic        lk_hit2;
    logic [31:0] lk_data1;
    logic [31:0] lk_data2;
    logic [2:0]  count;
    logic        drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_queue dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .rf_stall    (rf_stall),
        .rf_regWrite (rf_regWrite),
        .rf_wrAddr   (rf_wrAddr),
        .rf_wrData   (rf_wrData),
        .lk_addr1    (lk_addr1),
        .lk_addr2    (lk_addr2),
        .lk_hit1     (lk_hit1),
        .lk_hit2     (lk_hit2),
        .lk_data1    (lk_data1),
        .lk_data2    (lk_data2),
        .count       (count),
        .drop        (drop)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] addr, input logic [31:0] data, input logic stall);
        in_valid = valid;
        in_addr  = addr;
        in_data  = data;
        rf_stall = stall;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        lk_addr1 = '0;
        lk_addr2 = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_regWrite", 32'(rf_regWrite), 32'd0);
        checkOutput("reset_drop", 32'(drop), 32'd0);
        checkOutput("reset_wrAddr", 32'(rf_wrAddr), 32'd0);
        checkOutput("reset_hit1", 32'(lk_hit1), 32'd0);
        reset = 1'b0;

        $display("[TB] single push latency");
        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        checkOutput("t1_ready", 32'(in_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t1_regWrite", 32'(rf_regWrite), 32'd1);
        checkOutput("t1_wrAddr", 32'(rf_wrAddr), 32'd3);
        checkOutput("t1_wrData", rf_wrData, 32'hDEADBEEF);
        checkOutput("t1_count", 32'(count), 32'd1);
        nextCycle();
        checkOutput("t1_count_after", 32'(count), 32'd0);
        checkOutput("t1_regWrite_after", 32'(rf_regWrite), 32'd0);
        checkOutput("t1_wrData_empty", rf_wrData, 32'h0);

        $display("[TB] fill under stall");
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd1, 32'h33, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b1);
        nextCycle();
        lk_addr1 = 5'd1;
        lk_addr2 = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t2_count", 32'(count), 32'd4);
        checkOutput("t2_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_regWrite", 32'(rf_regWrite), 32'd0);
        checkOutput("t2_hit1", 32'(lk_hit1), 32'd1);
        checkOutput("t2_data1", lk_data1, 32'h33);
        checkOutput("t2_hit2", 32'(lk_hit2), 32'd0);
        checkOutput("t2_data2", lk_data2, 32'h0);
        applyStimulus(1'b1, 5'd20, 32'hBAD, 1'b1);
        checkOutput("t2_full_illegal_ready", 32'(in_ready), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t2_full_count", 32'(count), 32'd4);
        checkOutput("t2_full_drop", 32'(drop), 32'd0);

        $display("[TB] drain in order");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t3_ready_full_pop", 32'(in_ready), 32'd0);
        checkOutput("t3_regWrite0", 32'(rf_regWrite), 32'd1);
        checkOutput("t3_addr0", 32'(rf_wrAddr), 32'd1);
        checkOutput("t3_data0", rf_wrData, 32'h11);
        nextCycle();
        checkOutput("t3_count1", 32'(count), 32'd3);
        checkOutput("t3_addr1", 32'(rf_wrAddr), 32'd2);
        checkOutput("t3_data1", rf_wrData, 32'h22);
        nextCycle();
        checkOutput("t3_addr2", 32'(rf_wrAddr), 32'd1);
        checkOutput("t3_data2", rf_wrData, 32'h33);
        checkOutput("t3_lk_head", lk_data1, 32'h33);
        lk_addr2 = 5'd5;
        nextCycle();
        checkOutput("t3_addr3", 32'(rf_wrAddr), 32'd5);
        checkOutput("t3_data3", rf_wrData, 32'h55);
        checkOutput("t3_hit_popping", 32'(lk_hit2), 32'd1);
        checkOutput("t3_data_popping", lk_data2, 32'h55);
        nextCycle();
        checkOutput("t3_regWrite_done", 32'(rf_regWrite), 32'd0);
        checkOutput("t3_count_done", 32'(count), 32'd0);
        checkOutput("t3_hit_done", 32'(lk_hit2), 32'd0);

        $display("[TB] illegal address drop");
        lk_addr1 = 5'd0;
        lk_addr2 = 5'd0;
        applyStimulus(1'b1, 5'd20, 32'hBAD, 1'b0);
        checkOutput("t4_ready", 32'(in_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t4_drop", 32'(drop), 32'd1);
        checkOutput("t4_count", 32'(count), 32'd0);
        checkOutput("t4_regWrite", 32'(rf_regWrite), 32'd0);
        nextCycle();
        checkOutput("t4_drop_clear", 32'(drop), 32'd0);

        $display("[TB] streaming push and pop");
        applyStimulus(1'b1, 5'd0, 32'h1000, 1'b0);
        nextCycle();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0);
            checkOutput("t5_count", 32'(count), 32'd1);
            checkOutput("t5_wrAddr", 32'(rf_wrAddr), 32'(i - 1));
            checkOutput("t5_wrData", rf_wrData, 32'h1000 + 32'(i - 1));
            nextCycle();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t5_last_data", rf_wrData, 32'h100A);
        checkOutput("t5_last_count", 32'(count), 32'd1);
        nextCycle();
        checkOutput("t5_empty", 32'(count), 32'd0);

        $display("[TB] reset with pending entries");
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1);
        nextCycle();
        lk_addr1 = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t6_count_before", 32'(count), 32'd3);
        checkOutput("t6_hit_before", 32'(lk_hit1), 32'd1);
        reset = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_regWrite", 32'(rf_regWrite), 32'd0);
        checkOutput("t6_hit1", 32'(lk_hit1), 32'd0);
        reset = 1'b0;

        $display("[TB] same-address pushes");
        applyStimulus(1'b1, 5'd6, 32'hA, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd6, 32'hB, 1'b1);
        nextCycle();
        lk_addr1 = 5'd6;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t7_hit", 32'(lk_hit1), 32'd1);
        checkOutput("t7_data", lk_data1, 32'hB);
`ifdef REGFILE_WQ_COALESCE_EN
        checkOutput("t7_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t7_head", rf_wrData, 32'hB);
        nextCycle();
`else
        checkOutput("t7_count", 32'(count), 32'd2);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t7_head", rf_wrData, 32'hA);
        nextCycle();
        nextCycle();
`endif
        checkOutput("t7_drained", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Buffered writer for the 16-entry, single-write-port register file.
- Accepts write requests from multi-cycle producers (load unit, multiply/divide) through a valid/ready handshake and holds them in a small FIFO.
- Drains one entry per cycle into the register file write port whenever the main pipeline is not using that port.
- Provides two combinational lookup ports so decode can forward the newest pending value for a register that has not yet been written.

Parameters:
- DEPTH, 4: number of queue entries. Must be a power of 2, minimum 2.
- DATA_W, 32: write data width.
- ADDR_W, 5: register address width.
- NREGS, 16: number of implemented registers. Addresses >= NREGS are illegal.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a write request.
- in_ready  out  1  queue can accept a request this cycle.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  write value.
- rf_stall  in  1  main pipeline owns the register file write port this cycle.
- rf_regWrite  out  1  write strobe to the register file.
- rf_wrAddr  out  ADDR_W  register file write address.
- rf_wrData  out  DATA_W  register file write data.
- lk_addr1, lk_addr2  in  ADDR_W  decode read addresses.
- lk_hit1, lk_hit2  out  1  a pending entry matches the corresponding address.
- lk_data1, lk_data2  out  DATA_W  newest pending value for that address.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- drop  out  1  one-cycle registered pulse when an illegal address is discarded.

Behaviour:
- Reset:
  - Head pointer, tail pointer, count, and entry valid bits are cleared to 0; drop is 0.
  - Pending entries are discarded. A reset asserted mid-operation loses queued writes by design.
- Push:
  - in_ready = (count != DEPTH), combinational.
  - A handshake occurs when in_valid && in_ready.
  - Legal address: write {addr, data} at the tail, tail <= tail+1 mod DEPTH.
  - in_addr >= NREGS: nothing is enqueued, and drop pulses in the next cycle.
- Pop:
  - rf_regWrite = (count != 0) && !rf_stall, combinational.
  - rf_wrAddr and rf_wrData always show the head entry, and are 0 when empty.
  - When rf_regWrite is 1, head <= head+1 mod DEPTH and the register file commits on the same clk edge.
- Latency: a push into an empty queue with rf_stall=0 produces rf_regWrite on the next cycle, so the register file is updated 2 edges after the handshake.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full queue: in_ready=0 even if a pop occurs this cycle (no combinational ready-from-pop path).
- rf_stall held high: the queue holds its state and fills up, then backpressures the producer.
- Lookup:
  - Each port searches all valid entries and returns the youngest match (closest to the tail).
  - No match: hit=0 and data=0.
  - The head entry being popped this cycle still counts as a hit.
  - The lookup does not include the request currently on in_*.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: REGFILE_WQ_COALESCE_EN.
- Defined: when a legal push targets the same address as the youngest valid entry, and that entry is not being popped this cycle, its data is overwritten in place and no new entry is allocated.
  - in_ready is then also 1 when full, provided in_valid and the address matches the youngest entry.
- Undefined: every legal push allocates an entry and in_ready = !full.

Decomposition:
- Package regfile_wq_pkg contains:
  - the DATA_W, ADDR_W, and NREGS constants;
  - typedef wq_entry_t {logic valid; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data}.
- Sub-module wq_match_lookup: youngest-match priority search over the entry array, indexed relative to tail. It is instantiated twice, once per lookup port.

Test Plan:
- Reset, then push (3, 0xDEADBEEF) with rf_stall=0 -> next cycle rf_regWrite=1, rf_wrAddr=3, rf_wrData=0xDEADBEEF, and count returns to 0 after that edge.
- rf_stall=1, push 4 entries (1,0x11), (2,0x22), (1,0x33), (5,0x55) -> count=4 and in_ready=0; lk_addr1=1 gives hit=1, data=0x33; lk_addr2=7 gives hit=0, data=0.
- From the full state, release rf_stall -> writes drain in order 1/0x11, 2/0x22, 1/0x33, 5/0x55 on 4 consecutive cycles, then rf_regWrite=0.
- Push to address 20 -> nothing enqueued, count unchanged, drop=1 for exactly one cycle.
- Continuous push and pop for 10 cycles with rf_stall=0 -> count stays at 1, and pointer wrap-around produces no data loss or reordering.
- Assert reset with 3 entries queued -> count=0, rf_regWrite=0, lk_hit1=0 on the next cycle.
- With REGFILE_WQ_COALESCE_EN defined: rf_stall=1, push (6,0xA) then (6,0xB) -> count=1 and lookup of 6 returns 0xB.
